// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
// Optional watchdog is controlled by UART_ARB_TIMEOUT_EN (see uart_tx_arb).
package uart_arb_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    // Requester index width, clog2(n) with a floor of one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, with wrap-around.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt_c,
    output logic             o_found_c
);

    logic [IW-1:0] w_idx;

    // Search starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        o_gnt_c   = '0;
        o_found_c = 1'b0;
        w_idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            w_idx = IW'((32'(i_ptr) + i) % N_REQ);
            if (!o_found_c && i_req[w_idx]) begin
                o_gnt_c[w_idx] = 1'b1;
                o_found_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one uart_tx among N_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog driving timeout_o.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [BYTE_W*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic [BYTE_W-1:0]       tx_din_o,
    output logic                    tx_start_o,
    input  logic                    tx_done_tick_i,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t          r_state;
    logic [IW-1:0]       r_ptr;
    logic [N_REQ-1:0]    r_ready;
    logic [N_REQ-1:0]    r_grant;
    logic [BYTE_W-1:0]   r_tx_din;
    logic                r_start;
    logic                r_busy;
    logic [GW-1:0]       r_gap_cnt;

    logic [N_REQ-1:0]    w_gnt;
    logic                w_found;
    logic [BYTE_W-1:0]   w_byte;
    logic [IW-1:0]       w_grant_idx;
    logic                w_done;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req     (req_valid_i),
        .i_ptr     (r_ptr),
        .o_gnt_c   (w_gnt),
        .o_found_c (w_found)
    );

    // Byte of the picked requester, latched at the IDLE decision.
    always_comb begin
        w_byte = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) w_byte = req_data_i[k*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        w_grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) w_grant_idx = IW'(k);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    // Counter holds the current WAIT_DONE cycle number; expiry is treated as a done tick.
    assign w_done = tx_done_tick_i | r_timeout;
`else
    logic w_unused_to;
    assign w_unused_to = |TIMEOUT_CYCLES;
    assign w_done      = tx_done_tick_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IW'(N_REQ - 1);
            r_ready   <= '0;
            r_grant   <= '0;
            r_tx_din  <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_LAUNCH;
                        r_tx_din <= w_byte;
                        r_start  <= 1'b1;
                        r_ready  <= w_gnt;
                        r_grant  <= w_gnt;
                        r_busy   <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    r_ptr   <= w_grant_idx;
                    r_state <= ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    r_to_cnt  <= TW'(1);
                    r_timeout <= (TIMEOUT_CYCLES == 1);
`endif
                end
                ST_WAIT_DONE: begin
                    if (w_done) begin
                        if (GAP_CYCLES > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        r_to_cnt  <= r_to_cnt + TW'(1);
                        r_timeout <= (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign grant_o     = r_grant;
    assign tx_din_o    = r_tx_din;
    assign tx_start_o  = r_start;
    assign busy_o      = r_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_o   = r_timeout;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Round-robin arbiter and sequencer sharing one uart_tx instance among N_REQ byte requesters. Each requester offers a byte with a valid/ready handshake. The block grants one requester and pulses the UART start. It waits for the UART done tick, inserts an optional inter-frame gap, then re-arbitrates. It sits between the producer logic (command/status units) and uart_tx.

Parameters:
N_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle clk cycles inserted after each done tick before the next launch (0 = no gap state)
TIMEOUT_CYCLES, 20000, WAIT_DONE watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous reset, active-high
req_valid_i  input  N_REQ  per-requester byte valid; held until matching ready pulse
req_data_i  input  8*N_REQ  byte for requester k in bits [8k+7:8k]
req_ready_o  output  N_REQ  one-cycle accept pulse, one-hot
grant_o  output  N_REQ  one-hot owner of the UART from LAUNCH through end of GAP; 0 in IDLE
tx_din_o  output  8  byte to uart_tx din_i; stable from LAUNCH until leaving WAIT_DONE
tx_start_o  output  1  one-cycle pulse to uart_tx tx_start_i
tx_done_tick_i  input  1  uart_tx tx_done_tick_o
busy_o  output  1  high in any state except IDLE
timeout_o  output  1  one-cycle pulse on watchdog expiry (tied 0 without macro)

Behaviour:
- Single clock and synchronous active-high reset. All outputs are registered.
- Reset values: req_ready_o=0, grant_o=0, tx_din_o=8'h00, tx_start_o=0, busy_o=0, timeout_o=0, state=IDLE, last-grant pointer=N_REQ-1 (requester 0 wins first).
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE: if any req_valid_i is set, pick the first set bit searching from pointer+1 with wrap-around. Latch the winner index and its byte. Next state is LAUNCH. With no valid bits, stay in IDLE.
- LAUNCH (exactly 1 cycle): tx_start_o=1, req_ready_o[winner]=1, grant_o=winner, tx_din_o=latched byte. Pointer updates to winner. Next state is WAIT_DONE.
- Latency: valid seen in IDLE at cycle t gives tx_start_o and ready at t+1. Minimum back-to-back spacing is done tick plus 1 cycle (GAP_CYCLES=0) or plus GAP_CYCLES+1.
- WAIT_DONE: hold grant and tx_din_o. On tx_done_tick_i, go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Pointer and grant are held.
- tx_done_tick_i in IDLE, LAUNCH or GAP is ignored.
- A new valid coincident with a done tick is not launched that cycle; it is arbitrated in the following IDLE.
- Data is latched at the IDLE decision. If the winner drops valid before LAUNCH (protocol violation), the latched byte is still sent and ready still pulses.
- Requesters that are not granted keep valid asserted with no penalty. Round-robin guarantees each waiting requester is served within N_REQ frames.
- Reset mid-frame: return to IDLE immediately and drop grant. No resend is attempted; uart_tx is expected to share the same reset.

Optional Feature:
Macro: UART_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_DONE and clears on entry. When it reaches TIMEOUT_CYCLES without a done tick, timeout_o pulses for 1 cycle and the FSM proceeds as if a done tick arrived (GAP or IDLE).
- Undefined: no counter is built, timeout_o is constant 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package/include uart_arb_pkg: state encodings (IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2, GAP=2'd3), the index-width constant clog2(N_REQ), and the byte width 8.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and a found flag.

Test Plan:
1. Single request: req 0 valid with 8'hA5 in IDLE -> tx_start_o and req_ready_o=4'b0001 one cycle later, tx_din_o=8'hA5 until done tick; busy_o falls 1 cycle after the done tick.
2. Fairness: all 4 valid continuously with bytes 8'h10/8'h21/8'h32/8'h43 -> launch order 0,1,2,3,0; each ready is a single one-hot pulse.
3. Gap: GAP_CYCLES=5, two back-to-back requests -> exactly 6 cycles between done tick and the second tx_start_o.
4. Coincidence: req 2 asserts 8'h3C in the same cycle as the done tick -> no start that cycle; start 8'h3C at done+2 (GAP_CYCLES=0).
5. Reset mid-frame: assert rst during WAIT_DONE -> next cycle all outputs at reset values; after release, req 0 wins first.
6. Timeout (macro on, TIMEOUT_CYCLES=50): done tick withheld -> timeout_o pulses at cycle 50 of WAIT_DONE, then the next queued request is launched.
